// File: rtl/vga_pkg.sv
// Shared types and display-mode defaults for the frame-buffer arbiter.
// Holds the arbiter FSM encoding, the RGB444 pixel layout and per-mode geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FETCH = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int VGA_H_PIX  = 640;
    localparam int VGA_V_PIX  = 480;
    localparam int QVGA_H_PIX = 320;
    localparam int QVGA_V_PIX = 240;
    localparam int LB_ADDR_W  = 10;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display line fetches take strict priority
// over single-word camera writes; fetched pixels stream into a line buffer.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_PIX  = VGA_H_PIX,
    parameter int V_PIX  = VGA_V_PIX,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [9:0]        disp_line,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] H_PIX_A  = ADDR_W'(H_PIX);
    localparam logic [9:0]        IDX_LAST = 10'(H_PIX - 1);

    fb_state_t           r_state;
    fb_state_t           w_next;
    logic                r_pend;
    logic                r_ovr;
    logic                r_tail;
    logic                r_done;
    logic [9:0]          r_idx;
    logic [ADDR_W-1:0]   r_base;
    logic                r_lb_vld_p1;
    logic [9:0]          r_lb_addr_p1;

    logic                w_busy;
    logic                w_line_ok;
    logic                w_disp_acc;
    logic                w_fetch_go;
    logic                w_rd;
    logic                w_last_rd;
    logic [ADDR_W-1:0]   w_base;

    // A request is busy-rejected while one is queued or a line is streaming.
    assign w_busy     = r_pend | (r_state == ST_FETCH);
    assign w_line_ok  = (32'(disp_line) < V_PIX);
    assign w_disp_acc = disp_req & ~w_busy & w_line_ok;
    assign w_fetch_go = r_pend | w_disp_acc;
    assign w_rd       = (r_state == ST_FETCH) & ~r_tail;
    assign w_last_rd  = w_rd & (r_idx == IDX_LAST);
    assign w_base     = ADDR_W'(disp_line) * H_PIX_A;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Same-cycle disp_req is seen directly so it beats a simultaneous cam_req.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fetch_go) begin
                    w_next = ST_FETCH;
                end else if (cam_req) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: w_next = ST_IDLE;
            ST_FETCH: begin
                if (r_tail) begin
                    w_next = ST_IDLE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cam_ack   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == ST_WRITE) begin
            cam_ack   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cam_addr;
            mem_wdata = cam_data;
        end else if (w_rd) begin
            mem_en    = 1'b1;
            mem_addr  = r_base + ADDR_W'(r_idx);
        end
    end

    // Control: pending flag, sticky overrun, read index and trailing cycle.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_pend      <= 1'b0;
            r_ovr       <= 1'b0;
            r_tail      <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= '0;
            r_lb_vld_p1 <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_pend <= 1'b0;
            end else if (w_disp_acc) begin
                r_pend <= 1'b1;
            end
            if (disp_req && w_busy) begin
                r_ovr <= 1'b1;
            end
            if (w_last_rd) begin
                r_tail <= 1'b1;
                r_idx  <= '0;
            end else if (w_rd) begin
                r_idx  <= r_idx + 10'd1;
            end else if (r_tail) begin
                r_tail <= 1'b0;
            end
            r_done      <= (r_state == ST_FETCH) & r_tail;
            r_lb_vld_p1 <= w_rd;
        end
    end

    // Data path: line base captured with the request, read index delayed one cycle.
    always_ff @(posedge pclk) begin
        if (w_disp_acc) begin
            r_base <= w_base;
        end
        r_lb_addr_p1 <= r_idx;
    end

    assign lb_we      = r_lb_vld_p1;
    assign lb_addr    = r_lb_vld_p1 ? r_lb_addr_p1 : '0;
    assign lb_wdata   = r_lb_vld_p1 ? mem_rdata : '0;
    assign fetch_done = r_done;
    assign overrun    = r_ovr;

endmodule
